// File: rtl/fetch_prefetch_stage.sv
// Stage-one fetch: owns the PC, issues imem reads and buffers returned words for decode.
// Issue stops once buffered plus outstanding words reach DEPTH. A redirect flushes everything and drains stale reads.
module fetch_prefetch_stage #(
  parameter int IW       = 16,
  parameter int AW       = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt_sys,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [IW-1:0]            imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_instr,
  output logic [AW-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] STEP_W   = AW'(PC_STEP);
  localparam logic [AW-1:0] RST_PC_W = AW'(RESET_PC);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_drop_cnt, w_drop_nxt;
  logic [AW-1:0]   r_pc;
  logic [CW-1:0]   r_inflight;

  logic [AW-1:0]   r_tag_mem [DEPTH];
  logic [PW-1:0]   r_tag_wp, r_tag_rp;

  logic [IW-1:0]   r_instr_mem [DEPTH];
  logic [AW-1:0]   r_pcq_mem [DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count;

  logic            w_req, w_fire, w_rsp, w_pop;
  logic [CW:0]     w_reserved;

  // Slots already promised: words buffered plus reads still owed by memory.
  assign w_reserved = {1'b0, r_count} + {1'b0, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    w_req       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_req = !rst && !halt_sys && !redirect_valid && (w_reserved < DEPTH_W);
        if (redirect_valid) begin
          w_drop_nxt  = r_inflight + CW'(w_req && imem_gnt) - CW'(imem_rvalid);
          w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        if (redirect_valid || imem_rvalid)
          w_drop_nxt = r_drop_cnt - CW'(imem_rvalid);
        if (w_drop_nxt == '0)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign w_fire    = w_req && imem_gnt;
  assign w_rsp     = (r_state == S_RUN) && imem_rvalid && !redirect_valid;
  assign out_valid = (r_count != '0) && !halt_sys;
  assign w_pop     = out_valid && out_ready && !redirect_valid;
  assign out_instr = r_instr_mem[r_rp];
  assign out_pc    = r_pcq_mem[r_rp];
  assign occupancy = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RST_PC_W;
      r_inflight <= '0;
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      // Outstanding reads move to r_drop_cnt; the queues restart empty.
      r_pc       <= redirect_pc;
      r_inflight <= '0;
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
    end else begin
      if (w_fire) begin
        r_pc     <= r_pc + STEP_W;
        r_tag_wp <= r_tag_wp + PW'(1);
      end
      if (w_rsp) begin
        r_tag_rp <= r_tag_rp + PW'(1);
        r_wp     <= r_wp + PW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + PW'(1);
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rsp);
      r_count    <= r_count + CW'(w_rsp) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_mem[i]   <= '0;
        r_instr_mem[i] <= '0;
        r_pcq_mem[i]   <= '0;
      end
    end else begin
      if (w_fire)
        r_tag_mem[r_tag_wp] <= r_pc;
      if (w_rsp) begin
        r_instr_mem[r_wp] <= imem_rdata;
        r_pcq_mem[r_wp]   <= r_tag_mem[r_tag_rp];
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_RUN && imem_rvalid) |-> (r_inflight != '0));

endmodule
